sprite_line_renderer: RTL and testbench
=======================================

Name: sprite_line_renderer

Overview:
- Upstream neighbour of the palette-to-RGB stage; produces one 4-bit palette index per screen pixel, index 0 = transparent.
- Uses a ping-pong pair of line buffers. While line N is displayed from one bank, the FSM walks the sprite table and fetches sprite ROM rows for line N+1 into the other bank.
- Banks swap on each line_start pulse from the VGA timing logic.

Parameters:
- MAX_SPRITES, 8, sprite table entries; index 0 has highest priority.
- SPR_W, 16, sprite width in pixels.
- SPR_H, 16, sprite height in rows.
- SCREEN_W, 640, visible pixels per line; buffer depth per bank.
- XY_W, 10, width of screen coordinates.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  synchronous, active-low reset.
- line_start  in  1  one-cycle pulse, once per line before the line's first active pixel.
- next_y  in  XY_W  screen row to render into the back bank; sampled with line_start.
- spr_idx  out  $clog2(MAX_SPRITES)  sprite table read address.
- spr_valid  in  1  entry enabled; 1-cycle read latency after spr_idx.
- spr_x, spr_y  in  XY_W each  entry top-left position.
- spr_id  in  4  sprite image number.
- rom_addr  out  4+$clog2(SPR_H)+$clog2(SPR_W)  {id,row,col}; 1-cycle latency.
- rom_data  in  4  palette index from the sprite ROM.
- DrawX  in  XY_W  current display column.
- palette  out  4  index for DrawX, registered, 1-cycle latency; feeds the palette-to-RGB stage.
- busy  out  1  high while the FSM is not IDLE.
- overrun  out  1  one-cycle pulse when line_start arrives before render completes.

Behaviour:
- Reset:
  - palette=0, busy=1, overrun=0, display bank=0, state=INIT.
  - INIT writes 0 to every address of both banks: SCREEN_W cycles, both banks written in parallel.
  - INIT then moves to IDLE with busy=0.
  - line_start during INIT is ignored and does not pulse overrun.
- Display side:
  - Each cycle reads front[DrawX]; palette <= that value on the next cycle.
  - Clear-on-read: the same cycle writes 0 to front[DrawX], so the bank is clean when it becomes the back bank.
  - DrawX >= SCREEN_W: palette <= 0 and no write.
- line_start, accepted in any state except INIT:
  - Swap banks and latch next_y.
  - spr_idx <= MAX_SPRITES-1; go to SCAN.
  - Sprites are processed in descending index, so lower indices overwrite later (higher priority).
- SCAN (2 cycles per entry: address, then data):
  - Row hit when spr_valid and next_y - spr_y < SPR_H, as an unsigned XY_W subtraction (wrap makes rows above the sprite a miss).
  - Hit: row = next_y - spr_y, col=0, go to FETCH.
  - Miss, or after FETCH: if spr_idx==0 go to IDLE, else decrement spr_idx and stay in SCAN.
- FETCH:
  - Issues rom_addr for col 0..SPR_W-1, one per cycle.
  - Write pipeline runs one cycle behind: when rom_data != 0 and spr_x+col < SCREEN_W, write back[spr_x+col] <= rom_data.
  - Zero pixels and off-screen columns are not written, so they never erase underlying pixels.
  - Duration is SPR_W+1 cycles including drain.
- Worst-case line cost is MAX_SPRITES*(2+SPR_W+1) = 152 cycles, well under the 800-cycle line period.
- line_start while state is SCAN or FETCH:
  - overrun pulses for 1 cycle.
  - The in-flight write is dropped and the FSM restarts SCAN for the new line.
  - The partially rendered back bank is displayed as is.
- Simultaneous display clear and render write: they always target different banks, so there is no conflict.
- Reset_n low mid-operation re-enters INIT on the next edge, regardless of state.

Decomposition:
- Package sprite_pkg:
  - state_t enum {INIT, IDLE, SCAN, FETCH}.
  - SPR_W, SPR_H, SCREEN_W constants.
  - TRANSPARENT_IDX = 4'h0.
- One sub-module, line_bank_ram: dual-port SCREEN_W x 4 RAM with one read/write port and one write port; instantiated twice.
- Bank select, swap and the FSM stay in the top level.

Test Plan:
- Reset:
  - Stimulus: hold Reset_n low 3 cycles, then release.
  - Required: busy high for exactly 640 cycles; palette=0 for every DrawX on the first two lines.
- Single sprite:
  - Stimulus: entry 0 = {valid, x=100, y=50, id=3}; ROM row 2 = alternating 5,0; line_start with next_y=52.
  - Required: on the next displayed line, palette=5 at DrawX 100,102,...,114 and 0 at 101,...,115 and elsewhere.
- Priority:
  - Stimulus: entries 0 and 1 overlap at x=200; entry 0 solid 7, entry 1 solid 9.
  - Required: columns 200-215 show 7.
- Right-edge clip:
  - Stimulus: sprite at x=632.
  - Required: columns 632-639 drawn; no write beyond 639; the following line's column 0 is unchanged.
- Miss:
  - Stimulus: next_y=49 (above sprite) and next_y=66 (below sprite).
  - Required: no pixels drawn.
- Overrun:
  - Stimulus: all 8 sprites hit; pulse line_start again 40 cycles after the first.
  - Required: overrun=1 for exactly one cycle; FSM in SCAN with spr_idx=7 the following cycle.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and geometry for the sprite line renderer.
package sprite_pkg;

  typedef enum logic [1:0] {INIT, IDLE, SCAN, FETCH} state_t;

  localparam int unsigned SPR_W    = 16;
  localparam int unsigned SPR_H    = 16;
  localparam int unsigned SCREEN_W = 640;

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

endpackage

// File: rtl/line_bank_ram.sv
// One line buffer bank: port A reads combinationally and may write (display clear),
// port B is write-only (init / render).
module line_bank_ram #(
  parameter int unsigned Depth = 640,
  parameter int unsigned Width = 4,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic [AddrW-1:0] a_addr_i,
  input  logic             a_we_i,
  input  logic [Width-1:0] a_wdata_i,
  output logic [Width-1:0] a_rdata_o,
  input  logic [AddrW-1:0] b_addr_i,
  input  logic             b_we_i,
  input  logic [Width-1:0] b_wdata_i
);

  logic [Width-1:0] mem_q [Depth];

  assign a_rdata_o = mem_q[a_addr_i];

  always_ff @(posedge clk_i) begin
    if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
    if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
  end

endmodule

// File: rtl/sprite_line_renderer.sv
// Ping-pong line renderer: the front bank is displayed and cleared on read while the
// FSM composes the next line's sprites into the back bank.
module sprite_line_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned MAX_SPRITES = 8,
  parameter int unsigned XY_W        = 10
) (
  input  logic                                     Clk,
  input  logic                                     Reset_n,
  input  logic                                     line_start,
  input  logic [XY_W-1:0]                          next_y,
  output logic [$clog2(MAX_SPRITES)-1:0]           spr_idx,
  input  logic                                     spr_valid,
  input  logic [XY_W-1:0]                          spr_x,
  input  logic [XY_W-1:0]                          spr_y,
  input  logic [3:0]                               spr_id,
  output logic [4+$clog2(SPR_H)+$clog2(SPR_W)-1:0] rom_addr,
  input  logic [3:0]                               rom_data,
  input  logic [XY_W-1:0]                          DrawX,
  output logic [3:0]                               palette,
  output logic                                     busy,
  output logic                                     overrun
);

  localparam int unsigned IdxW  = $clog2(MAX_SPRITES);
  localparam int unsigned RowW  = $clog2(SPR_H);
  localparam int unsigned ColW  = $clog2(SPR_W);
  localparam int unsigned CntW  = ColW + 1;
  localparam int unsigned AddrW = $clog2(SCREEN_W);

  state_t          state_q, state_d;
  logic            bank_q, bank_d;
  logic [XY_W-1:0] y_q, y_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            phase_q, phase_d;
  logic [AddrW-1:0] init_q, init_d;
  logic [CntW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [3:0]      id_q, id_d;
  logic [XY_W-1:0] x_q, x_d;
  logic            wr_valid_q, wr_valid_d;
  logic [XY_W:0]   wr_x_q, wr_x_d;
  logic [3:0]      palette_q, palette_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;

  logic [XY_W-1:0]  row_diff;
  logic             accept, disp_we, rend_we;
  logic [AddrW-1:0] b_addr;
  logic [3:0]       b_wdata;
  logic [3:0]       rd_bank [2];

  assign accept   = line_start && (state_q != INIT);
  assign disp_we  = DrawX < XY_W'(SCREEN_W);
  // A write still in the pipe when a new line starts belongs to a dead line.
  assign rend_we  = wr_valid_q && !accept && (rom_data != TRANSPARENT_IDX) &&
                    (wr_x_q < (XY_W+1)'(SCREEN_W));
  assign b_addr   = (state_q == INIT) ? init_q : wr_x_q[AddrW-1:0];
  assign b_wdata  = (state_q == INIT) ? TRANSPARENT_IDX : rom_data;
  assign row_diff = y_q - spr_y;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    line_bank_ram #(
      .Depth(SCREEN_W),
      .Width(4)
    ) u_ram (
      .clk_i    (Clk),
      .a_addr_i (DrawX[AddrW-1:0]),
      .a_we_i   (disp_we && (bank_q == 1'(b))),
      .a_wdata_i(TRANSPARENT_IDX),
      .a_rdata_o(rd_bank[b]),
      .b_addr_i (b_addr),
      .b_we_i   ((state_q == INIT) || (rend_we && (bank_q != 1'(b)))),
      .b_wdata_i(b_wdata)
    );
  end

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    y_d        = y_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    init_d     = init_q;
    col_d      = col_q;
    row_d      = row_q;
    id_d       = id_q;
    x_d        = x_q;
    wr_valid_d = 1'b0;
    wr_x_d     = wr_x_q;
    overrun_d  = 1'b0;
    palette_d  = (state_q == INIT || !disp_we) ? TRANSPARENT_IDX : rd_bank[bank_q];

    unique case (state_q)
      INIT: begin
        init_d = init_q + AddrW'(1);
        if (init_q == AddrW'(SCREEN_W - 1)) state_d = IDLE;
      end
      IDLE: ;
      SCAN: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (spr_valid && (row_diff < XY_W'(SPR_H))) begin
            row_d   = row_diff[RowW-1:0];
            col_d   = '0;
            id_d    = spr_id;
            x_d     = spr_x;
            state_d = FETCH;
          end else if (idx_q == '0) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q - IdxW'(1);
          end
        end
      end
      FETCH: begin
        if (col_q == CntW'(SPR_W)) begin
          if (idx_q == '0) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q - IdxW'(1);
            state_d = SCAN;
          end
        end else begin
          col_d      = col_q + CntW'(1);
          wr_valid_d = 1'b1;
          wr_x_d     = {1'b0, x_q} + (XY_W+1)'(col_q);
        end
      end
      default: state_d = INIT;
    endcase

    if (accept) begin
      bank_d     = ~bank_q;
      y_d        = next_y;
      idx_d      = IdxW'(MAX_SPRITES - 1);
      phase_d    = 1'b0;
      state_d    = SCAN;
      wr_valid_d = 1'b0;
      overrun_d  = (state_q == SCAN) || (state_q == FETCH);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= INIT;
      bank_q     <= 1'b0;
      y_q        <= '0;
      idx_q      <= '0;
      phase_q    <= 1'b0;
      init_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      id_q       <= '0;
      x_q        <= '0;
      wr_valid_q <= 1'b0;
      wr_x_q     <= '0;
      palette_q  <= TRANSPARENT_IDX;
      busy_q     <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      y_q        <= y_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      init_q     <= init_d;
      col_q      <= col_d;
      row_q      <= row_d;
      id_q       <= id_d;
      x_q        <= x_d;
      wr_valid_q <= wr_valid_d;
      wr_x_q     <= wr_x_d;
      palette_q  <= palette_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign spr_idx  = idx_q;
  assign rom_addr = {id_q, row_q, col_q[ColW-1:0]};
  assign palette  = palette_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Scoreboarded bench: each displayed pixel's expected index comes from a line-composition
// model evaluated from the sprite table and ROM contents at each line_start.
module tb_sprite_line_renderer;

  localparam int NS   = 8;
  localparam int SW   = 640;
  localparam int LINE = 800;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  next_y = '0;
  logic [2:0]  spr_idx;
  logic        spr_valid;
  logic [9:0]  spr_x, spr_y;
  logic [3:0]  spr_id;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data;
  logic [9:0]  DrawX = '0;
  logic [3:0]  palette;
  logic        busy, overrun;

  always #5 Clk = ~Clk;

  sprite_line_renderer #(
    .MAX_SPRITES(8),
    .XY_W       (10)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .line_start(line_start),
    .next_y    (next_y),
    .spr_idx   (spr_idx),
    .spr_valid (spr_valid),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .spr_id    (spr_id),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .DrawX     (DrawX),
    .palette   (palette),
    .busy      (busy),
    .overrun   (overrun)
  );

  typedef struct {int cyc; int x; int val; bit care;} exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ov_cnt = 0;

  bit tv[NS];
  int tx[NS], ty[NS], tid[NS];
  bit nv[NS];
  int nx[NS], ny[NS], nid[NS];
  logic [3:0] rom [4096];
  int shown[SW], pending[SW];
  bit dc = 0, post_pulse = 0, post_extra = 0;

  // Sprite table and ROM, each with one cycle of read latency.
  always @(posedge Clk) begin
    spr_valid <= tv[spr_idx];
    spr_x     <= 10'(tx[spr_idx]);
    spr_y     <= 10'(ty[spr_idx]);
    spr_id    <= 4'(tid[spr_idx]);
    rom_data  <= rom[rom_addr];
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: palette for the pixel issued in the previous cycle.
  initial forever begin
    @(negedge Clk);
    if (overrun) ov_cnt++;
    if (sbq.size() > 0 && sbq[0].cyc == cyc - 1) begin
      exp_t e;
      e = sbq.pop_front();
      if (e.care) begin
        n_checks++;
        if (palette !== 4'(e.val)) begin
          n_errors++;
          $display("FAIL palette x=%0d got=%0d want=%0d", e.x, palette, e.val);
        end
      end
    end
  end

  // Each screen pixel takes the lowest-index sprite with an opaque pixel there.
  function automatic void render(input int y);
    for (int x = 0; x < SW; x++) pending[x] = 0;
    for (int i = 0; i < NS; i++) begin
      int row;
      row = (y - ty[i]) & 1023;
      if (tv[i] && row < 16) begin
        for (int c = 0; c < 16; c++) begin
          int x, p;
          x = tx[i] + c;
          p = int'(rom[tid[i] * 256 + row * 16 + c]);
          if (x < SW && p != 0 && pending[x] == 0) pending[x] = p;
        end
      end
    end
  endfunction

  task automatic set_blank();
    for (int i = 0; i < NS; i++) begin
      nv[i] = 0; nx[i] = 0; ny[i] = 0; nid[i] = 0;
    end
  endtask

  task automatic set_n(input int i, input int x, input int y, input int id);
    nv[i] = 1; nx[i] = x; ny[i] = y; nid[i] = id;
  endtask

  task automatic set_random(input int y);
    for (int i = 0; i < NS; i++) begin
      nv[i]  = ($urandom_range(0, 3) != 0);
      nx[i]  = $urandom_range(0, 660);
      ny[i]  = (y - (int'($urandom_range(0, 24)) - 4)) & 1023;
      nid[i] = $urandom_range(0, 15);
    end
  endtask

  // One 800-cycle line; line_start at the last cycle, plus optionally at extra_at.
  task automatic run_line(input int y, input int extra_at);
    for (int c = 0; c < LINE; c++) begin
      bit ls;
      @(posedge Clk);
      #1;
      if (post_pulse) begin
        check(post_extra ? "overrun_pulse" : "no_overrun", int'(overrun), int'(post_extra));
        check("restart_idx", int'(spr_idx), NS - 1);
        check("restart_scan", int'(dut.state_q == sprite_pkg::SCAN), 1);
        post_pulse = 0;
      end
      if (c == 700) check("render_done", int'(busy), 0);
      if (c == 600) begin
        for (int i = 0; i < NS; i++) begin
          tv[i] = nv[i]; tx[i] = nx[i]; ty[i] = ny[i]; tid[i] = nid[i];
        end
      end
      ls = (c == LINE - 1) || (c == extra_at);
      DrawX = 10'(c);
      line_start = ls;
      next_y = 10'(y);
      sbq.push_back('{cyc, c, (c < SW) ? shown[c] : 0, !(dc && c < SW)});
      if (ls) begin
        for (int x = 0; x < SW; x++) shown[x] = pending[x];
        render(y);
        dc = (c != LINE - 1);
        post_pulse = 1;
        post_extra = (c != LINE - 1);
      end
    end
  endtask

  task automatic do_reset(input int ignored_pulse_at);
    int n;
    @(negedge Clk);
    Reset_n = 1'b0;
    line_start = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_palette", int'(palette), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_overrun", int'(overrun), 0);
    Reset_n = 1'b1;
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      if (!busy) break;
      n++;
      line_start = (k == ignored_pulse_at);
      @(posedge Clk);
      @(negedge Clk);
    end
    line_start = 1'b0;
    check("init_busy_cycles", n, SW);
    for (int x = 0; x < SW; x++) begin
      shown[x] = 0; pending[x] = 0;
    end
    dc = 0;
    post_pulse = 0;
  endtask

  initial begin
    int y;
    for (int a = 0; a < 4096; a++)
      rom[a] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    for (int c = 0; c < 16; c++) begin
      rom[3 * 256 + 2 * 16 + c] = (c % 2 == 0) ? 4'd5 : 4'd0;
      for (int r = 0; r < 16; r++) begin
        rom[1 * 256 + r * 16 + c] = 4'd7;
        rom[2 * 256 + r * 16 + c] = 4'd9;
        rom[4 * 256 + r * 16 + c] = 4'd6;
      end
    end
    set_blank();
    for (int i = 0; i < NS; i++) begin
      tv[i] = 0; tx[i] = 0; ty[i] = 0; tid[i] = 0;
    end

    do_reset(100);
    run_line(0, -1);
    run_line(0, -1);

    set_n(0, 100, 50, 3);
    run_line(52, -1);
    run_line(49, -1);
    run_line(66, -1);

    set_blank();
    set_n(0, 200, 10, 1);
    set_n(1, 200, 10, 2);
    run_line(12, -1);

    set_blank();
    set_n(0, 632, 20, 4);
    run_line(25, -1);

    set_blank();
    run_line(0, -1);

    for (int l = 0; l < 6; l++) begin
      y = $urandom_range(0, 479);
      set_random(y);
      run_line(y, -1);
    end

    set_blank();
    for (int i = 0; i < NS; i++) set_n(i, 100 + 60 * i, 100 + i % 3, $urandom_range(0, 15));
    run_line(500, -1);
    run_line(105, -1);
    run_line(110, 39);
    set_blank();
    run_line(0, -1);
    run_line(0, -1);

    y = $urandom_range(0, 479);
    set_random(y);
    run_line(y, -1);
    do_reset(100);

    set_blank();
    set_n(0, 100, 50, 3);
    run_line(52, -1);
    set_blank();
    run_line(0, -1);
    run_line(0, -1);

    @(posedge Clk);
    #1;
    line_start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("overrun_pulses", ov_cnt, 1);
    check("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
